video_timing: RTL and testbench

Free-running raster timing generator for the 312-line progressive PAL composite path. It counts clock cycles per line and lines per frame, and decodes the raster position into sync, burst, visible-area and pixel-strobe signals. It sits directly upstream of the pattern/colour-bar generators, feeding their `newline`, `newpixel`, `video_x`, `video_y`, `visible_line` and `visible_window` inputs. `sync` and `burst` go to the composite encoder.

---
 rtl/video_timing.sv | 148 ++++++++++++++
 tb/tb_video_timing.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/video_timing.sv
// video_timing: free-running PAL raster timing generator.
// Counts clocks per line and lines per frame. It decodes the raster position
// into sync, burst, visible-area and pixel-strobe flags. Every flag is computed
// from the next counter state and registered, so each flag lines up with the
// video_x/video_y value that it describes.
module video_timing #(
    parameter int CLKS_PER_LINE = 3072,
    parameter int LINES         = 312,
    parameter int HSYNC_CLKS    = 226,
    parameter int VSYNC_LINES   = 3,
    parameter int BURST_START   = 269,
    parameter int BURST_CLKS    = 108,
    parameter int ACTIVE_START  = 500,
    parameter int ACTIVE_CLKS   = 2560,
    parameter int FIRST_LINE    = 40,
    parameter int ACTIVE_LINES  = 256,
    parameter int PIXEL_DIV     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [12:0] video_x,
    output logic [8:0]  video_y,
    output logic        newline,
    output logic        frame_start,
    output logic        newpixel,
    output logic        visible_line,
    output logic        visible_window,
    output logic        sync,
    output logic        burst,
    output logic        line_odd
);

    localparam int PW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

    // Raster constants at counter width, so comparisons carry no width casts.
    localparam logic [12:0] X_LAST       = 13'(CLKS_PER_LINE - 1);
    localparam logic [12:0] X_HSYNC_END  = 13'(HSYNC_CLKS);
    localparam logic [12:0] X_HALF       = 13'(CLKS_PER_LINE / 2);
    localparam logic [12:0] X_BROAD1_END = 13'(CLKS_PER_LINE / 2 - HSYNC_CLKS);
    localparam logic [12:0] X_BROAD2_END = 13'(CLKS_PER_LINE - HSYNC_CLKS);
    localparam logic [12:0] X_BURST      = 13'(BURST_START);
    localparam logic [12:0] X_BURST_END  = 13'(BURST_START + BURST_CLKS);
    localparam logic [12:0] X_ACT        = 13'(ACTIVE_START);
    localparam logic [12:0] X_ACT_END    = 13'(ACTIVE_START + ACTIVE_CLKS);
    localparam logic [8:0]  Y_LAST       = 9'(LINES - 1);
    localparam logic [8:0]  Y_VSYNC_END  = 9'(VSYNC_LINES);
    localparam logic [8:0]  Y_FIRST      = 9'(FIRST_LINE);
    localparam logic [8:0]  Y_FIRST_END  = 9'(FIRST_LINE + ACTIVE_LINES);
    localparam logic [PW-1:0] P_LAST     = PW'(PIXEL_DIV - 1);

    // Parameter sanity: the counters must fit, and the picture must never overlap sync or burst.
    if (CLKS_PER_LINE % 2 != 0 || CLKS_PER_LINE > 8192) begin : g_bad_line
        $error("CLKS_PER_LINE must be even and fit 13 bits");
    end
    if (LINES > 512 || FIRST_LINE + ACTIVE_LINES > LINES) begin : g_bad_lines
        $error("LINES must fit 9 bits and contain the visible lines");
    end
    if (PIXEL_DIV < 1 || ACTIVE_CLKS % PIXEL_DIV != 0) begin : g_bad_pdiv
        $error("ACTIVE_CLKS must be a multiple of PIXEL_DIV");
    end
    if (ACTIVE_START < HSYNC_CLKS || ACTIVE_START < BURST_START + BURST_CLKS ||
        ACTIVE_START + ACTIVE_CLKS > CLKS_PER_LINE || FIRST_LINE < VSYNC_LINES) begin : g_bad_window
        $error("visible window overlaps sync or burst");
    end

    logic [12:0]   x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic [PW-1:0] pdiv_q, pdiv_d;
    logic          odd_q, odd_d;
    logic          newline_q, newline_d;
    logic          frame_q, frame_d;
    logic          newpixel_q, newpixel_d;
    logic          vline_q, vline_d;
    logic          vwin_q, vwin_d;
    logic          sync_q, sync_d;
    logic          burst_q, burst_d;
    logic          x_wrap;
    logic          vsync_line;

    // Next counter state, then decode the flags from that next state.
    always_comb begin
        // NOTE: every signal gets its value first on every path, so this block infers no latch.
        x_wrap     = (x_q == X_LAST);
        x_d        = x_wrap ? '0 : x_q + 13'd1;
        y_d        = y_q;
        if (x_wrap) begin
            y_d = (y_q == Y_LAST) ? '0 : y_q + 9'd1;
        end
        odd_d      = odd_q ^ x_wrap;
        pdiv_d     = (x_d == X_ACT || pdiv_q == P_LAST) ? '0 : pdiv_q + PW'(1);

        newline_d  = x_wrap;
        frame_d    = x_wrap && (y_q == Y_LAST);
        vline_d    = (y_d >= Y_FIRST) && (y_d < Y_FIRST_END);
        vwin_d     = vline_d && (x_d >= X_ACT) && (x_d < X_ACT_END);
        newpixel_d = vwin_d && (pdiv_d == '0);

        vsync_line = (y_d < Y_VSYNC_END);
        if (vsync_line) begin
            sync_d = (x_d < X_BROAD1_END) || ((x_d >= X_HALF) && (x_d < X_BROAD2_END));
        end else begin
            sync_d = (x_d < X_HSYNC_END);
        end
        burst_d    = !vsync_line && (x_d >= X_BURST) && (x_d < X_BURST_END);
    end

    // State and output registers; reset clears everything, including pulses in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            pdiv_q     <= '0;
            odd_q      <= 1'b0;
            newline_q  <= 1'b0;
            frame_q    <= 1'b0;
            newpixel_q <= 1'b0;
            vline_q    <= 1'b0;
            vwin_q     <= 1'b0;
            sync_q     <= 1'b0;
            burst_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the same pre-edge state.
            x_q        <= x_d;
            y_q        <= y_d;
            pdiv_q     <= pdiv_d;
            odd_q      <= odd_d;
            newline_q  <= newline_d;
            frame_q    <= frame_d;
            newpixel_q <= newpixel_d;
            vline_q    <= vline_d;
            vwin_q     <= vwin_d;
            sync_q     <= sync_d;
            burst_q    <= burst_d;
        end
    end

    assign video_x        = x_q;
    assign video_y        = y_q;
    assign newline        = newline_q;
    assign frame_start    = frame_q;
    assign newpixel       = newpixel_q;
    assign visible_line   = vline_q;
    assign visible_window = vwin_q;
    assign sync           = sync_q;
    assign burst          = burst_q;
    assign line_odd       = odd_q;

endmodule

// File: tb/tb_video_timing.sv
// tb_video_timing: scoreboard bench for video_timing with a small raster.
// A reference model derives every output from the number of clock edges since
// reset, using plain arithmetic. It pushes the expected output for each edge
// into a queue. A monitor pops one entry per edge and compares it with the
// DUT. The stimulus asserts reset at random points in the raster.
module tb_video_timing;

    localparam int CPL = 64;
    localparam int LN  = 12;
    localparam int HS  = 5;
    localparam int VS  = 2;
    localparam int BS  = 6;
    localparam int BC  = 4;
    localparam int AS  = 12;
    localparam int AC  = 45;
    localparam int FL  = 3;
    localparam int AL  = 7;
    localparam int PD  = 5;

    typedef struct packed {
        logic [12:0] x;
        logic [8:0]  y;
        logic        newline;
        logic        frame_start;
        logic        newpixel;
        logic        visible_line;
        logic        visible_window;
        logic        sync;
        logic        burst;
        logic        line_odd;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [12:0] video_x;
    logic [8:0]  video_y;
    logic        newline, frame_start, newpixel, visible_line, visible_window;
    logic        sync, burst, line_odd;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   t_model = 0;
    bit   done    = 1'b0;
    out_t exp_q[$];

    video_timing #(
        .CLKS_PER_LINE(CPL), .LINES(LN), .HSYNC_CLKS(HS), .VSYNC_LINES(VS),
        .BURST_START(BS), .BURST_CLKS(BC), .ACTIVE_START(AS), .ACTIVE_CLKS(AC),
        .FIRST_LINE(FL), .ACTIVE_LINES(AL), .PIXEL_DIV(PD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .video_x(video_x), .video_y(video_y),
        .newline(newline), .frame_start(frame_start), .newpixel(newpixel),
        .visible_line(visible_line), .visible_window(visible_window),
        .sync(sync), .burst(burst), .line_odd(line_odd)
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t o;
        o = '{video_x, video_y, newline, frame_start, newpixel,
              visible_line, visible_window, sync, burst, line_odd};
        return o;
    endfunction

    // Expected outputs t edges after reset release (t >= 1).
    function automatic out_t model(int t);
        out_t o;
        int   x, line, y;
        x    = t % CPL;
        line = t / CPL;
        y    = line % LN;
        o.x              = 13'(x);
        o.y              = 9'(y);
        o.newline        = (x == 0);
        o.frame_start    = (x == 0) && (y == 0);
        o.visible_line   = (y >= FL) && (y < FL + AL);
        o.visible_window = o.visible_line && (x >= AS) && (x < AS + AC);
        o.newpixel       = o.visible_window && ((x - AS) % PD == 0);
        if (y < VS) o.sync = (x < CPL/2 - HS) || ((x >= CPL/2) && (x < CPL - HS));
        else        o.sync = (x < HS);
        o.burst          = (y >= VS) && (x >= BS) && (x < BS + BC);
        o.line_odd       = (line % 2) == 1;
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d flags=%b, expected x=%0d y=%0d flags=%b",
                     name, act.x, act.y, act[7:0], exp.x, exp.y, exp[7:0]);
        end
    endtask

    // Reference model: one expected entry per clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            t_model = 0;
            exp_q.push_back('0);
        end else begin
            t_model++;
            exp_q.push_back(model(t_model));
        end
    end

    // Monitor: compare the DUT with the oldest expected entry, away from the edge.
    always @(posedge clk) begin
        #1;
        if (!done) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: queue empty at time %0t", $time);
            end else begin
                check("cycle", sample(), exp_q.pop_front());
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", sample(), '0);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        // Two full frames plus part of a third cover frame wrap and line_odd phase.
        run(2 * CPL * LN + 100);
        for (int i = 0; i < 5; i++) begin
            pulse_reset($urandom_range(1, 3));
            run($urandom_range(50, 900));
        end
        pulse_reset(3);
        run(CPL * LN + 2 * CPL);
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
